// File: rtl/router_pkg.sv
// Shared router types: allocator FSM states and port index width.
package router_pkg;
  localparam int NUM_PORTS = 5;
  typedef logic [$clog2(NUM_PORTS)-1:0] port_idx_t;
  typedef enum logic {SA_IDLE, SA_LOCKED} sa_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, wrapping at N-1.
module rr_arbiter
  import router_pkg::*;
#(
  parameter int N = 5,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        gnt[j] = 1'b1;
        idx    = W'(j);
        any    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator with wormhole locking.
// Optional lock watchdog built when SA_WATCHDOG_EN is defined.
//
// state     | meaning
// SA_IDLE   | output free; head flits compete round-robin from ptr
// SA_LOCKED | output held by owner until its tail flit is granted
module switch_allocator
  import router_pkg::*;
#(
  parameter int NUM_IN   = 5,
  parameter int NUM_OUT  = 5,
  parameter int IN_W     = $clog2(NUM_IN),
  parameter int OUT_W    = $clog2(NUM_OUT),
  parameter int WD_LIMIT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN-1:0]       i_req,
  input  logic [NUM_IN*OUT_W-1:0] i_dest,
  input  logic [NUM_IN-1:0]       i_head,
  input  logic [NUM_IN-1:0]       i_tail,
  input  logic [NUM_OUT-1:0]      i_out_ready,
  output logic [NUM_IN-1:0]       o_grant,
  output logic [NUM_OUT*IN_W-1:0] o_sel,
  output logic [NUM_OUT-1:0]      o_sel_valid,
  output logic [NUM_OUT-1:0]      o_locked,
  output logic [NUM_OUT-1:0]      o_wd_err
);
  sa_state_t         state    [NUM_OUT];
  logic [IN_W-1:0]   owner    [NUM_OUT];
  logic [IN_W-1:0]   ptr      [NUM_OUT];
  logic [NUM_IN-1:0] elig     [NUM_OUT];
  logic [NUM_IN-1:0] arb_req  [NUM_OUT];
  logic [NUM_IN-1:0] arb_gnt  [NUM_OUT];
  logic [IN_W-1:0]   arb_idx  [NUM_OUT];
  logic              arb_any  [NUM_OUT];
  logic              take     [NUM_OUT];
  logic [IN_W-1:0]   take_idx [NUM_OUT];
  logic              take_tail[NUM_OUT];
  logic [NUM_IN-1:0] gnt_d;

  function automatic logic [IN_W-1:0] next_idx(input logic [IN_W-1:0] i);
    return (int'(i) == NUM_IN - 1) ? '0 : i + 1'b1;
  endfunction

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_arb
    rr_arbiter #(.N(NUM_IN), .W(IN_W)) u_arb (
      .req(arb_req[g]),
      .ptr(ptr[g]),
      .gnt(arb_gnt[g]),
      .idx(arb_idx[g]),
      .any(arb_any[g])
    );
  end

  // o_grant masks the flit already being popped this cycle
  always_comb begin
    for (int o = 0; o < NUM_OUT; o++) begin
      for (int i = 0; i < NUM_IN; i++)
        elig[o][i] = i_req[i] && (i_dest[i*OUT_W +: OUT_W] == OUT_W'(o)) &&
                     i_out_ready[o] && !o_grant[i];
      arb_req[o] = elig[o] & i_head;
    end
  end

  always_comb begin
    gnt_d = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      if (state[o] == SA_IDLE) begin
        take[o]     = arb_any[o];
        take_idx[o] = arb_idx[o];
        gnt_d       = gnt_d | arb_gnt[o];
      end else begin
        take[o]     = elig[o][owner[o]] && !i_head[owner[o]];
        take_idx[o] = owner[o];
        if (take[o]) gnt_d[owner[o]] = 1'b1;
      end
      take_tail[o] = i_tail[take_idx[o]];
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_OUT; o++) o_locked[o] = (state[o] == SA_LOCKED);
  end

`ifdef SA_WATCHDOG_EN
  localparam int WD_W = ($clog2(WD_LIMIT + 1) > 8) ? $clog2(WD_LIMIT + 1) : 8;
  logic [WD_W-1:0] wd_cnt [NUM_OUT];
`else
  assign o_wd_err = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      o_grant     <= '0;
      o_sel       <= '0;
      o_sel_valid <= '0;
      for (int o = 0; o < NUM_OUT; o++) begin
        state[o] <= SA_IDLE;
        owner[o] <= '0;
        ptr[o]   <= '0;
`ifdef SA_WATCHDOG_EN
        wd_cnt[o]   <= '0;
        o_wd_err[o] <= 1'b0;
`endif
      end
    end else begin
      o_grant <= gnt_d;
      for (int o = 0; o < NUM_OUT; o++) begin
        o_sel_valid[o]           <= take[o];
        o_sel[o*IN_W +: IN_W]    <= take[o] ? take_idx[o] : '0;
        if (take[o]) begin
          if (take_tail[o]) begin
            state[o] <= SA_IDLE;
            ptr[o]   <= next_idx(take_idx[o]);
          end else begin
            state[o] <= SA_LOCKED;
            owner[o] <= take_idx[o];
          end
        end
`ifdef SA_WATCHDOG_EN
        // a stalled owner releases the output after WD_LIMIT idle cycles
        if (state[o] == SA_LOCKED && !take[o]) begin
          if (wd_cnt[o] == WD_W'(WD_LIMIT - 1)) begin
            state[o]    <= SA_IDLE;
            ptr[o]      <= next_idx(owner[o]);
            o_wd_err[o] <= 1'b1;
            wd_cnt[o]   <= '0;
          end else begin
            wd_cnt[o] <= wd_cnt[o] + 1'b1;
          end
        end else begin
          wd_cnt[o] <= '0;
        end
`endif
      end
    end
  end
endmodule
